// File: rtl/mc_controller.sv
// Control FSM for the multicycle MIPS datapath with a mem_req/mem_ready memory handshake.
// Define IMMLOGIC_EN to add andi/ori support through the LOGEX state.
module mc_controller #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       immzext,
  output logic       err,
  output logic [3:0] state
);

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_IWB    = 4'd10,
    S_JEX    = 4'd11,
    S_LOGEX  = 4'd12
  } state_t;

  state_t        state_q;
  logic          err_q;
  logic [CW-1:0] wait_cnt;
  logic          mem_state;
  logic          timeout;
  logic          mem_done;
  logic          pcwrite;
  logic          branch;

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return ALU_ADD;
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  // A timed-out access is abandoned: the request drops and nothing completes.
  always_comb begin
    mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout   = (WAIT_LIMIT != 0) && mem_state && (wait_cnt == CW'(WAIT_LIMIT));
    mem_done  = mem_state && !timeout && mem_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else if (timeout) begin
      state_q  <= S_FETCH;
      err_q    <= 1'b1;
      wait_cnt <= '0;
    end else begin
      if (mem_state && !mem_ready)
        wait_cnt <= wait_cnt + CW'(1);
      else
        wait_cnt <= '0;

      case (state_q)
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= S_RTEX;
            OP_BEQ:       state_q <= S_BEQEX;
            OP_ADDI:      state_q <= S_ADDIEX;
            OP_J:         state_q <= S_JEX;
`ifdef IMMLOGIC_EN
            OP_ANDI, OP_ORI: state_q <= S_LOGEX;
`endif
            default:      state_q <= S_FETCH;
          endcase
        end
        S_MEMADR: state_q <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
        S_RTEX:   state_q <= S_RTWB;
        S_RTWB:   state_q <= S_FETCH;
        S_BEQEX:  state_q <= S_FETCH;
        S_ADDIEX: state_q <= S_IWB;
        S_IWB:    state_q <= S_FETCH;
        S_JEX:    state_q <= S_FETCH;
        S_LOGEX:  state_q <= S_IWB;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the datapath controls; enables are then qualified by mem_ready and reset.
  always_comb begin
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b000;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    immzext    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = mem_done;
        pcwrite    = mem_done;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_RTEX: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu(funct);
      end
      S_RTWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      S_IWB: begin
        regwrite = 1'b1;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      S_LOGEX: begin
`ifdef IMMLOGIC_EN
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        immzext    = 1'b1;
        alucontrol = (op == OP_ANDI) ? ALU_AND : ALU_OR;
`endif
      end
      default: begin
      end
    endcase

    if (timeout || reset) begin
      mem_req  = 1'b0;
      memwrite = 1'b0;
    end
    if (reset) begin
      irwrite  = 1'b0;
      regwrite = 1'b0;
    end
    pcen = (pcwrite || (branch && zero)) && !reset;
  end

  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized scoreboard bench for mc_controller: instruction-level reference model
// expands each instruction into expected per-cycle outputs; a monitor compares them.
module tb_mc_controller;

  localparam int LIMIT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, iord, irwrite, pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       regwrite, regdst, memtoreg, immzext, err;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_controller #(.WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcen(pcen),
    .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .immzext(immzext),
    .err(err), .state(state)
  );

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       immzext;
    logic       err;
    logic [3:0] state;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       mr;
    logic       zr;
    logic [5:0] op;
    logic [5:0] funct;
    exp_t       e;
  } cyc_t;

  cyc_t       pend[$];
  cyc_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc_n = 0;
  bit         err_m = 1'b0;
  logic [5:0] cur_op = '0;
  logic [5:0] cur_funct = '0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t blank(input int st);
    exp_t e;
    e       = '0;
    e.state = 4'(st);
    e.err   = err_m;
    return e;
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs of a memory-access state (0 fetch, 3 load, 5 store).
  function automatic exp_t mem_exp(input int st, input bit done, input bit to);
    exp_t e;
    e         = blank(st);
    e.mem_req = !to;
    if (st == 0) begin
      e.alusrcb    = 2'b01;
      e.alucontrol = 3'b010;
      e.irwrite    = done;
      e.pcen       = done;
    end else begin
      e.iord = 1'b1;
    end
    if (st == 5) e.memwrite = !to;
    return e;
  endfunction

  function automatic exp_t step_exp(input int st, input logic zr);
    exp_t e;
    e = blank(st);
    case (st)
      1:  begin e.alusrcb = 2'b11; e.alucontrol = 3'b010; end
      2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 3'b010; end
      4:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
      6:  begin e.alusrca = 1'b1; e.alucontrol = alu_of(cur_funct); end
      7:  begin e.regwrite = 1'b1; e.regdst = 1'b1; end
      8:  begin e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = zr; end
      9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 3'b010; end
      10: begin e.regwrite = 1'b1; end
      11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      12: begin
        e.alusrca    = 1'b1;
        e.alusrcb    = 2'b10;
        e.immzext    = 1'b1;
        e.alucontrol = (cur_op == 6'b001100) ? 3'b000 : 3'b001;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t gate_reset(input exp_t e);
    exp_t g;
    g          = e;
    g.mem_req  = 1'b0;
    g.memwrite = 1'b0;
    g.irwrite  = 1'b0;
    g.pcen     = 1'b0;
    g.regwrite = 1'b0;
    return g;
  endfunction

  task automatic step(input exp_t e, input logic mr, input logic zr);
    cyc_t c;
    c.rst   = 1'b0;
    c.mr    = mr;
    c.zr    = zr;
    c.op    = cur_op;
    c.funct = cur_funct;
    c.e     = e;
    pend.push_back(c);
  endtask

  task automatic plain(input int st);
    logic zr;
    zr = rb();
    step(step_exp(st, zr), rb(), zr);
  endtask

  // Memory access with a random number of wait cycles; too many waits abort the instruction.
  task automatic mem_access(input int st, output bit ok);
    int w;
    w  = (rb() == 1'b1) ? 0 : int'($urandom_range(1, LIMIT + 1));
    ok = 1'b1;
    for (int i = 0; i < w && i < LIMIT; i++) step(mem_exp(st, 1'b0, 1'b0), 1'b0, rb());
    if (w >= LIMIT) begin
      step(mem_exp(st, 1'b0, 1'b1), rb(), rb());
      err_m = 1'b1;
      ok    = 1'b0;
    end else begin
      step(mem_exp(st, 1'b1, 1'b0), 1'b1, rb());
    end
  endtask

  task automatic gen_instr();
    int         kind;
    bit         ok;
    logic [5:0] others [4] = '{6'b111111, 6'b010000, 6'b000101, 6'b100000};
    logic [5:0] rfuncts[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    kind = $urandom_range(0, 9);
    case (kind)
      0:       cur_op = 6'b100011;
      1:       cur_op = 6'b101011;
      2, 3:    cur_op = 6'b000000;
      4:       cur_op = 6'b000100;
      5:       cur_op = 6'b001000;
      6:       cur_op = 6'b000010;
      7:       cur_op = 6'b001100;
      8:       cur_op = 6'b001101;
      default: cur_op = others[$urandom_range(0, 3)];
    endcase
    cur_funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : rfuncts[$urandom_range(0, 4)];

    mem_access(0, ok);
    if (ok) begin
      plain(1);
      case (cur_op)
        6'b100011: begin
          plain(2);
          mem_access(3, ok);
          if (ok) plain(4);
        end
        6'b101011: begin
          plain(2);
          mem_access(5, ok);
        end
        6'b000000: begin plain(6); plain(7); end
        6'b000100: plain(8);
        6'b001000: begin plain(9); plain(10); end
        6'b000010: plain(11);
`ifdef IMMLOGIC_EN
        6'b001100, 6'b001101: begin plain(12); plain(10); end
`endif
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input cyc_t c);
    @(posedge clk);
    #1;
    reset     = c.rst;
    mem_ready = c.mr;
    zero      = c.zr;
    op        = c.op;
    funct     = c.funct;
    sb.push_back(c);
  endtask

  // Replays the expanded instruction, occasionally cutting it short with a reset.
  task automatic flush();
    int   k;
    cyc_t c;
    k = pend.size();
    if ($urandom_range(0, 14) == 0) k = $urandom_range(0, pend.size() - 1);
    for (int i = 0; i < k; i++) applyStimulus(pend[i]);
    if (k < pend.size()) begin
      c     = pend[k];
      c.rst = 1'b1;
      c.e   = gate_reset(c.e);
      applyStimulus(c);
      err_m = 1'b0;
    end
    pend.delete();
  endtask

  task automatic checkOutput(input cyc_t c);
    exp_t a;
    a.mem_req    = mem_req;
    a.memwrite   = memwrite;
    a.iord       = iord;
    a.irwrite    = irwrite;
    a.pcen       = pcen;
    a.pcsrc      = pcsrc;
    a.alusrca    = alusrca;
    a.alusrcb    = alusrcb;
    a.alucontrol = alucontrol;
    a.regwrite   = regwrite;
    a.regdst     = regdst;
    a.memtoreg   = memtoreg;
    a.immzext    = immzext;
    a.err        = err;
    a.state      = state;
    tests++;
    if (a !== c.e) begin
      fails++;
      $display("[TB] FAIL cycle %0d outputs (rst=%b op=%b mr=%b): actual=%b required=%b",
               cyc_n, c.rst, c.op, c.mr, a, c.e);
    end
  endtask

  always @(negedge clk) begin
    cyc_t c;
    cyc_n++;
    if (sb.size() > 0) begin
      c = sb.pop_front();
      checkOutput(c);
    end
  end

  initial begin
    cyc_t c;
    reset     = 1'b1;
    mem_ready = 1'b1;
    zero      = 1'b0;
    op        = '0;
    funct     = '0;

    c.rst   = 1'b1;
    c.mr    = 1'b1;
    c.zr    = 1'b0;
    c.op    = '0;
    c.funct = '0;
    c.e     = gate_reset(mem_exp(0, 1'b1, 1'b0));
    applyStimulus(c);
    applyStimulus(c);

    for (int n = 0; n < 400; n++) begin
      gen_instr();
      flush();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Main control FSM for the multicycle MIPS datapath instantiated under top. It decodes op/funct from the instruction register and sequences fetch, decode, execute, memory and writeback. It drives every datapath mux select and write enable, including ALU control. It handshakes with the unified instruction/data memory through mem_req/mem_ready, so memory may take several cycles per access.

Parameters:
WAIT_LIMIT, 0, max cycles a memory state waits for mem_ready; 0 = wait forever

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; FSM returns to FETCH
op  input  6  instr[31:26] from IR
funct  input  6  instr[5:0] from IR
zero  input  1  ALU zero flag (current cycle)
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
memwrite  output  1  write qualifier for mem_req
iord  output  1  0 = address from PC, 1 = from ALUOut
irwrite  output  1  load IR
pcen  output  1  PC load enable = pcwrite | (branch & zero)
pcsrc  output  2  00 ALU result, 01 ALUOut, 10 jump target
alusrca  output  1  0 = PC, 1 = register A
alusrcb  output  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
regwrite  output  1  register file write
regdst  output  1  0 = rt, 1 = rd
memtoreg  output  1  0 = ALUOut, 1 = MDR
immzext  output  1  1 = zero-extend immediate (see optional feature)
err  output  1  sticky memory timeout flag
state  output  4  current state encoding, debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, IWB=10, JEX=11, LOGEX=12.
- Outputs are Moore-decoded from state, except pcen, irwrite and the memory-state exits, which are qualified by mem_ready.
- On reset: state=FETCH, err=0. Every output not listed below is 0 by default.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00. Hold in FETCH until mem_ready. In the mem_ready cycle: irwrite=1, pcen=1, next=DECODE. With mem_ready tied high, FETCH lasts exactly 1 cycle.
- DECODE: alusrca=0, alusrcb=11, add, which precomputes the branch target into ALUOut. Next state by op:
  - 100011 lw and 101011 sw -> MEMADR
  - 000000 -> RTEX
  - 000100 beq -> BEQEX
  - 001000 addi -> ADDIEX
  - 000010 j -> JEX
  - any other op -> FETCH (executes as a NOP)
- MEMADR: alusrca=1, alusrcb=10, add. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then -> MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1 -> FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1. Hold until mem_ready, then -> FETCH.
- RTEX: alusrca=1, alusrcb=00, alucontrol from funct:
  - 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
  - unknown funct -> 010
  - next = RTWB
- RTWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1 so pcen=zero -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add -> IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
- JEX: pcsrc=10, pcen=1 -> FETCH.
- Instruction latencies with zero-wait memory: lw 5 cycles; sw, R-type, addi 4; beq, j 3.
- Timeout (WAIT_LIMIT>0): a cycle counter runs while in FETCH/MEMRD/MEMWR with mem_ready=0. It clears on every state change.
  - When the count reaches WAIT_LIMIT: set err=1, deassert mem_req, and go to FETCH without writing IR, PC, regfile or memory.
  - err stays set until reset.
- Reset asserted mid-access: FSM goes to FETCH on the next edge. mem_req drops in that cycle, and no write enable is asserted in the reset cycle.

Optional Feature:
IMMLOGIC_EN:
- When defined, op 001100 andi and 001101 ori decode to LOGEX.
- LOGEX: alusrca=1, alusrcb=10, immzext=1, alucontrol=000 (andi) or 001 (ori). Next = IWB.
- When undefined: LOGEX is unreachable, those opcodes behave as NOPs (DECODE -> FETCH), and immzext is constant 0.

Test Plan:
- Reset held 2 cycles, mem_ready=1 -> state=0, mem_req=1 at the first cycle after release; all write enables 0 during reset.
- op=100011, mem_ready=1 -> states 0,1,2,3,4,0; regwrite=1 with memtoreg=1 only in state 4.
- op=000000, funct=101010 -> RTEX alucontrol=111, then RTWB regwrite=1, regdst=1; funct=111111 -> alucontrol=010.
- op=000100, zero=1 then zero=0 -> pcen=1 with pcsrc=01 in BEQEX on the first run; pcen=0 on the second.
- sw with mem_ready low 3 cycles in MEMWR, WAIT_LIMIT=0 -> memwrite held 4 cycles, then FETCH; with WAIT_LIMIT=2 and mem_ready never asserted -> err=1 after 2 waiting cycles, state=0.
- op=001101 -> with IMMLOGIC_EN: states 0,1,12,10 with immzext=1 and alucontrol=001; without it: states 0,1,0 and regwrite never asserted.
